// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared constants, header layout and FSM encoding for the SPI frame controller.
package spi_frame_pkg;
    localparam logic [4:0] CMD_FIFO_RD = 5'h10;
    localparam int HDR_R       = 7;
    localparam int HDR_L       = 6;
    localparam int HDR_CMD_MSB = 4;
    localparam int ST_ILLEGAL  = 0;
    localparam int ST_SHORT    = 1;
    localparam int ST_UNDER    = 2;
    localparam int ST_OVER     = 3;
    localparam int MAX_LEN_DEF = 32;
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: REG_N x 8 configuration registers; the top register is the sticky STATUS word.
module spi_reg_bank
    import spi_frame_pkg::*;
#(
    parameter int REG_N = 8,
    localparam int AW = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [7:0]        wdata,
    input  logic [AW-1:0]     raddr,
    output logic [7:0]        rdata,
    input  logic [7:0]        st_set,
    input  logic              st_clr,
    output logic [REG_N*8-1:0] cfg
);
    localparam logic [AW-1:0] ST = AW'(REG_N - 1);

    logic [7:0] regs [REG_N];

    // STATUS is read-only to the host; a clear and a new set in one cycle keep the new bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            if (we && waddr != ST) regs[waddr] <= wdata;
            regs[ST] <= (st_clr ? 8'h00 : regs[ST]) | st_set;
        end
    end

    assign rdata = regs[raddr];

    always_comb begin
        cfg = '0;
        for (int i = 0; i < REG_N; i++) cfg[8*i +: 8] = regs[i];
    end
endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: decodes SPI frames (header, optional length, data) into register
// accesses or capture-FIFO streaming, and feeds transmit bytes back to the byte engine.
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int REG_N   = 8,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         spi_rx_data,
    input  logic               spi_eob,
    input  logic               spi_busy,
    output logic [7:0]         spi_tx_data,
    output logic               spi_err,
    input  logic [7:0]         fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    output logic [REG_N*8-1:0] cfg
);
    localparam int AW = $clog2(REG_N);
    localparam logic [AW-1:0] ST_ADDR = AW'(REG_N - 1);
    localparam logic [4:0] REG_N5 = 5'(REG_N);
    localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

    state_t state, state_nx;
    logic eob_q, rd_q, fifo_q, pend_q;
    logic [AW-1:0] addr_q, rd_addr;
    logic [5:0] cnt_q;
    logic [7:0] rd_data, status, st_set;
    logic [4:0] cmd;
    logic ev, hdr_ev, len_ev, data_ev, illegal, over, short_set;
    logic hdr_ok, is_fifo, use_fifo, load_rd, reg_load, pop_req, we, st_clr;

    assign ev      = spi_eob & ~eob_q;
    assign cmd     = spi_rx_data[HDR_CMD_MSB:0];
    assign is_fifo = cmd == CMD_FIFO_RD && spi_rx_data[HDR_R];
    assign hdr_ok  = cmd < REG_N5 || is_fifo;

    // busy low outranks a byte event arriving in the same cycle
    always_comb begin
        state_nx  = state;
        hdr_ev    = 1'b0;
        len_ev    = 1'b0;
        data_ev   = 1'b0;
        illegal   = 1'b0;
        over      = 1'b0;
        short_set = 1'b0;
        if (!spi_busy) begin
            state_nx  = S_IDLE;
            short_set = state == S_LEN || state == S_DATA;
        end else if (ev) begin
            case (state)
                S_IDLE: begin
                    hdr_ev   = 1'b1;
                    illegal  = !hdr_ok;
                    state_nx = !hdr_ok ? S_ERR : spi_rx_data[HDR_L] ? S_LEN : S_DATA;
                end
                S_LEN: begin
                    illegal  = spi_rx_data == 8'd0 || spi_rx_data > MAX_LEN8;
                    len_ev   = !illegal;
                    state_nx = illegal ? S_ERR : S_DATA;
                end
                S_DATA: begin
                    data_ev  = 1'b1;
                    state_nx = cnt_q == 6'd1 ? S_DONE : S_DATA;
                end
                S_DONE: begin
                    over     = 1'b1;
                    state_nx = S_ERR;
                end
                default: state_nx = state;
            endcase
        end
    end

    // the next read byte is fetched at the header and at every data byte except the last
    assign use_fifo = hdr_ev ? is_fifo : fifo_q;
    assign rd_addr  = hdr_ev ? cmd[AW-1:0] : addr_q;
    assign load_rd  = (hdr_ev && hdr_ok && spi_rx_data[HDR_R]) || (data_ev && rd_q && cnt_q > 6'd1);
    assign reg_load = load_rd && !use_fifo;
    assign pop_req  = load_rd && use_fifo;
    assign we       = data_ev && !rd_q;
    assign st_clr   = reg_load && rd_addr == ST_ADDR;
    assign status   = cfg[8*(REG_N-1) +: 8];

    always_comb begin
        st_set             = '0;
        st_set[ST_ILLEGAL] = illegal;
        st_set[ST_SHORT]   = short_set;
        st_set[ST_UNDER]   = pop_req && fifo_empty;
        st_set[ST_OVER]    = over;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            eob_q       <= 1'b0;
            rd_q        <= 1'b0;
            fifo_q      <= 1'b0;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            spi_tx_data <= '0;
            spi_err     <= 1'b0;
            fifo_rd     <= 1'b0;
        end else begin
            state   <= state_nx;
            eob_q   <= spi_eob;
            spi_err <= illegal | over;
            fifo_rd <= pop_req & ~fifo_empty;
            pend_q  <= fifo_rd;
            if (hdr_ev) begin
                rd_q   <= spi_rx_data[HDR_R];
                fifo_q <= is_fifo;
            end
            if (hdr_ev || reg_load || we) addr_q <= rd_addr + AW'(reg_load || we);
            cnt_q <= hdr_ev ? 6'd1 : len_ev ? spi_rx_data[5:0] : data_ev ? cnt_q - 6'd1 : cnt_q;
            // popped FIFO data arrives one cycle after the pop strobe
            if (reg_load) spi_tx_data <= rd_data;
            else if (pop_req && fifo_empty) spi_tx_data <= 8'h00;
            else if (pend_q) spi_tx_data <= fifo_data;
            else if (state == S_IDLE) spi_tx_data <= status;
        end
    end

    spi_reg_bank #(.REG_N(REG_N)) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (addr_q),
        .wdata  (spi_rx_data),
        .raddr  (rd_addr),
        .rdata  (rd_data),
        .st_set (st_set),
        .st_clr (st_clr),
        .cfg    (cfg)
    );
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed frames against a byte-level reference model of the frame protocol.
module tb_spi_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  spi_rx_data = 8'h00;
    logic        spi_eob = 1'b0;
    logic        spi_busy = 1'b0;
    logic [7:0]  spi_tx_data;
    logic        spi_err;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd;
    logic [63:0] cfg;

    always #5 clk = ~clk;

    spi_frame_ctrl #(.REG_N(8), .MAX_LEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_rx_data (spi_rx_data),
        .spi_eob     (spi_eob),
        .spi_busy    (spi_busy),
        .spi_tx_data (spi_tx_data),
        .spi_err     (spi_err),
        .fifo_data   (fifo_data),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .cfg         (cfg)
    );

    int checks = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // capture FIFO environment and strobe monitors
    byte unsigned fq[$];
    int pops = 0;
    int errs = 0;
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        if (fifo_rd) begin
            pops++;
            if (fq.size() > 0) fifo_data = fq.pop_front();
        end
        fifo_empty = fq.size() == 0;
        if (spi_err) begin
            errs++;
            check("err_one_cycle", {63'b0, err_prev}, 64'd0);
        end
        err_prev = spi_err;
    end

    // reference model: byte-by-byte interpretation of the frame protocol
    byte unsigned m_reg[8];
    byte unsigned mq[$];
    byte unsigned m_tx;
    int m_st = 0;
    int m_left, m_addr;
    int m_errs = 0;
    int m_pops = 0;
    bit m_rd, m_fifo;

    function automatic logic [63:0] m_cfg();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_reg[i];
        return r;
    endfunction

    task automatic m_load();
        if (m_fifo) begin
            if (mq.size() > 0) begin
                m_tx = mq.pop_front();
                m_pops++;
            end else begin
                m_tx = 8'h00;
                m_reg[7] |= 8'h04;
            end
        end else begin
            m_tx = m_reg[m_addr];
            if (m_addr == 7) m_reg[7] = 8'h00;
            m_addr = (m_addr + 1) % 8;
        end
    endtask

    task automatic m_err(input byte unsigned bit_mask);
        m_reg[7] |= bit_mask;
        m_errs++;
        m_st = 4;
    endtask

    task automatic m_byte(input byte unsigned b);
        int cmd;
        cmd = b & 8'h1F;
        case (m_st)
            0: begin
                if (cmd < 8 || (cmd == 16 && b[7])) begin
                    m_rd = b[7];
                    m_fifo = cmd == 16;
                    m_addr = cmd;
                    m_left = 1;
                    m_st = b[6] ? 1 : 2;
                    if (m_rd) m_load();
                end else m_err(8'h01);
            end
            1: begin
                if (b == 0 || b > 32) m_err(8'h01);
                else begin
                    m_left = b;
                    m_st = 2;
                end
            end
            2: begin
                if (!m_rd) begin
                    if (m_addr != 7) m_reg[m_addr] = b;
                    m_addr = (m_addr + 1) % 8;
                end else if (m_left > 1) m_load();
                m_left--;
                if (m_left == 0) m_st = 3;
            end
            3: m_err(8'h08);
            default: ;
        endcase
    endtask

    task automatic m_end();
        if (m_st == 1 || m_st == 2) m_reg[7] |= 8'h02;
        m_st = 0;
    endtask

    // continuous compare while inputs are settled
    bit quiet = 0;
    always @(negedge clk) begin
        if (quiet) begin
            check("cfg", cfg, m_cfg());
            if (m_st == 0) check("tx_idle_status", {56'b0, spi_tx_data}, {56'b0, m_reg[7]});
            else if (m_rd && (m_st == 1 || m_st == 2)) check("tx_read", {56'b0, spi_tx_data}, {56'b0, m_tx});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input byte unsigned b, input int hold = 1);
        quiet = 0;
        tick(1);
        spi_rx_data = b;
        spi_eob = 1'b1;
        tick(hold);
        spi_eob = 1'b0;
        tick(4);
        m_byte(b);
        quiet = 1;
        tick(2);
    endtask

    task automatic begin_frame();
        quiet = 0;
        tick(1);
        spi_busy = 1'b1;
        tick(3);
        quiet = 1;
        tick(1);
    endtask

    task automatic end_frame();
        quiet = 0;
        tick(1);
        spi_busy = 1'b0;
        tick(3);
        m_end();
        quiet = 1;
        tick(2);
        check("err_pulses", errs, m_errs);
        check("fifo_pops", pops, m_pops);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"}, {56'b0, spi_tx_data}, 64'd0);
        check({tag, "_err"}, {63'b0, spi_err}, 64'd0);
        check({tag, "_fifo_rd"}, {63'b0, fifo_rd}, 64'd0);
        check({tag, "_cfg"}, cfg, 64'd0);
    endtask

    initial begin
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(2);
        quiet = 1;

        begin_frame(); send(8'h03); send(8'hA5); end_frame();
        check("short_write_reg3", {56'b0, cfg[31:24]}, 64'hA5);
        check("short_write_no_err", errs, 0);

        begin_frame(); send(8'h83);
        check("short_read_reg3", {56'b0, spi_tx_data}, 64'hA5);
        send(8'h00); end_frame();

        begin_frame(); send(8'h40); send(8'h03); send(8'h11); send(8'h22); send(8'h33); end_frame();
        check("long_write_regs012", {40'b0, cfg[23:0]}, 64'h332211);

        begin_frame(); send(8'h46); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); end_frame();
        check("wrap_reg6", {56'b0, cfg[55:48]}, 64'hAA);
        check("wrap_reg0", {56'b0, cfg[7:0]}, 64'hCC);
        check("wrap_status_untouched", {56'b0, cfg[63:56]}, 64'h00);

        fq.push_back(8'h01); fq.push_back(8'h02);
        mq.push_back(8'h01); mq.push_back(8'h02);
        begin_frame();
        send(8'hD0); check("fifo_tx0", {56'b0, spi_tx_data}, 64'h01);
        send(8'h04); check("fifo_tx0_hold", {56'b0, spi_tx_data}, 64'h01);
        send(8'h00); check("fifo_tx1", {56'b0, spi_tx_data}, 64'h02);
        send(8'h00); check("fifo_tx2_under", {56'b0, spi_tx_data}, 64'h00);
        send(8'h00); check("fifo_tx3_under", {56'b0, spi_tx_data}, 64'h00);
        send(8'h00);
        end_frame();
        check("fifo_two_pops", pops, 2);
        check("fifo_underflow_status", {56'b0, cfg[63:56]}, 64'h04);

        begin_frame(); send(8'h87);
        check("status_read", {56'b0, spi_tx_data}, 64'h04);
        send(8'h00); end_frame();
        check("status_cleared", {56'b0, cfg[63:56]}, 64'h00);

        begin_frame(); send(8'h1F); send(8'h00); end_frame();
        check("illegal_cmd_status", {56'b0, cfg[63:56]}, 64'h01);
        check("illegal_cmd_err", errs, 1);

        begin_frame(); send(8'h40); send(8'h00); end_frame();
        begin_frame(); send(8'h40); send(8'h21); end_frame();
        check("bad_len_errs", errs, 3);

        begin_frame(); send(8'h02); send(8'h5A, 5); end_frame();
        check("held_eob_one_event", {56'b0, cfg[23:16]}, 64'h5A);
        check("held_eob_no_overrun", {56'b0, cfg[63:56]}, 64'h01);

        begin_frame(); send(8'h02); send(8'h5B); send(8'h99); end_frame();
        check("overrun_status", {56'b0, cfg[63:56]}, 64'h09);

        begin_frame(); send(8'h40); send(8'h03); send(8'h11); end_frame();
        check("short_frame_status", {56'b0, cfg[63:56]}, 64'h0B);

        begin_frame(); send(8'h44); send(8'h03); send(8'h77);
        quiet = 0;
        rst = 1'b0;
        tick(2);
        check_reset_outputs("midframe_reset");
        spi_busy = 1'b0;
        tick(1);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_st = 0;
        tick(2);
        quiet = 1;
        check("reset_no_err", errs, m_errs);
        begin_frame(); send(8'h01); send(8'h3C); end_frame();
        check("after_reset_write", {56'b0, cfg[15:8]}, 64'h3C);
        begin_frame(); send(8'h81);
        check("after_reset_read", {56'b0, spi_tx_data}, 64'h3C);
        send(8'h00); end_frame();

        quiet = 0;
        tick(2);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
